// File: rtl/la_clkreqor.sv
// N-channel clock-request combiner: ORs unmasked requests (plus force_on) into a
// registered clock-enable with programmable idle hysteresis before it drops.
module la_clkreqor #(
    parameter int N     = 4,
    parameter int HOLDW = 8,
    parameter     PROP  = "DEFAULT"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [HOLDW-1:0] hold,
    input  logic             force_on,
    output logic             en,
    output logic [N-1:0]     grant,
    output logic             wake,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [HOLDW-1:0] count;
    logic [HOLDW-1:0] next_count;
    logic             next_en;
    logic             next_wake;
    logic [N-1:0]     live_req;
    logic             any;

    assign live_req = req & ~mask;
    assign any      = (|live_req) | force_on;

    always_comb begin
        next_state = state;
        next_count = count;
        next_wake  = 1'b0;
        case (state)
            ST_OFF: begin
                if (any) begin
                    next_state = ST_ON;
                    next_wake  = 1'b1;
                end
            end
            ST_ON: begin
                if (!any) begin
                    if (hold != '0) begin
                        next_state = ST_HOLD;
                        next_count = hold - HOLDW'(1);
                    end else begin
                        next_state = ST_OFF;
                    end
                end
            end
            ST_HOLD: begin
                // A returning request beats expiry on the same edge; en never drops.
                if (any) begin
                    next_state = ST_ON;
                    next_count = '0;
                end else if (count == '0) begin
                    next_state = ST_OFF;
                end else begin
                    next_count = count - HOLDW'(1);
                end
            end
            default: begin
                next_state = ST_OFF;
                next_count = '0;
            end
        endcase
        next_en = (next_state != ST_OFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
            count <= '0;
            en    <= 1'b0;
            grant <= '0;
            wake  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            en    <= next_en;
            grant <= next_en ? live_req : '0;
            wake  <= next_wake;
            busy  <= next_en;
        end
    end

endmodule

// File: tb/tb_la_clkreqor.sv
// Directed bench for la_clkreqor: hand-computed en/wake/busy/grant per cycle.
module tb_la_clkreqor;

    localparam int N     = 4;
    localparam int HOLDW = 8;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic [HOLDW-1:0] hold;
    logic             force_on;
    logic             en;
    logic [N-1:0]     grant;
    logic             wake;
    logic             busy;

    int checks;
    int errors;

    la_clkreqor #(.N(N), .HOLDW(HOLDW), .PROP("DEFAULT")) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .mask     (mask),
        .hold     (hold),
        .force_on (force_on),
        .en       (en),
        .grant    (grant),
        .wake     (wake),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_en, input logic e_wake,
                              input logic e_busy, input logic [N-1:0] e_grant);
        check({tag, ".en"},    32'(en),    32'(e_en));
        check({tag, ".wake"},  32'(wake),  32'(e_wake));
        check({tag, ".busy"},  32'(busy),  32'(e_busy));
        check({tag, ".grant"}, 32'(grant), 32'(e_grant));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        req      = 4'b1111;
        mask     = '0;
        hold     = '0;
        force_on = 1'b0;

        // Reset held with all requests active.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("rst", 1'b0, 1'b0, 1'b0, 4'b0000);
        end
        reset = 1'b0;
        tick(); expect_out("rel0", 1'b1, 1'b1, 1'b1, 4'b1111);
        tick(); expect_out("rel1", 1'b1, 1'b0, 1'b1, 4'b1111);
        req = '0;
        tick(); expect_out("rel_off", 1'b0, 1'b0, 1'b0, 4'b0000);

        // hold=3: 5 request cycles then exactly 3 idle cycles of en.
        hold = 8'd3;
        req  = 4'b0010;
        tick(); expect_out("h3_on0", 1'b1, 1'b1, 1'b1, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out("h3_on", 1'b1, 1'b0, 1'b1, 4'b0010);
        end
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("h3_hold", 1'b1, 1'b0, 1'b1, 4'b0000);
        end
        tick(); expect_out("h3_off", 1'b0, 1'b0, 1'b0, 4'b0000);

        // hold=5: reassert 2 cycles into HOLD; no drop, no second wake.
        hold = 8'd5;
        req  = 4'b0001;
        tick(); expect_out("h5_on0", 1'b1, 1'b1, 1'b1, 4'b0001);
        tick(); expect_out("h5_on1", 1'b1, 1'b0, 1'b1, 4'b0001);
        req = '0;
        tick(); expect_out("h5_hold0", 1'b1, 1'b0, 1'b1, 4'b0000);
        tick(); expect_out("h5_hold1", 1'b1, 1'b0, 1'b1, 4'b0000);
        req = 4'b0001;
        tick(); expect_out("h5_back", 1'b1, 1'b0, 1'b1, 4'b0001);
        req  = '0;
        hold = '0;
        tick(); expect_out("h5_off", 1'b0, 1'b0, 1'b0, 4'b0000);

        // hold=0 single-cycle pulse.
        req = 4'b0100;
        tick(); expect_out("h0_pulse", 1'b1, 1'b1, 1'b1, 4'b0100);
        req = '0;
        tick(); expect_out("h0_off", 1'b0, 1'b0, 1'b0, 4'b0000);

        // Masking and force_on.
        mask = 4'b0100;
        req  = 4'b0100;
        tick(); expect_out("mask0", 1'b0, 1'b0, 1'b0, 4'b0000);
        tick(); expect_out("mask1", 1'b0, 1'b0, 1'b0, 4'b0000);
        mask = '0;
        tick(); expect_out("unmask", 1'b1, 1'b1, 1'b1, 4'b0100);
        req      = '0;
        force_on = 1'b1;
        tick(); expect_out("force", 1'b1, 1'b0, 1'b1, 4'b0000);
        force_on = 1'b0;
        tick(); expect_out("force_off", 1'b0, 1'b0, 1'b0, 4'b0000);
        force_on = 1'b1;
        tick(); expect_out("force_wake", 1'b1, 1'b1, 1'b1, 4'b0000);
        force_on = 1'b0;
        mask     = 4'b1000;
        req      = 4'b1000;
        tick(); expect_out("mask_drop", 1'b0, 1'b0, 1'b0, 4'b0000);
        mask = '0;
        req  = '0;

        // Reset during HOLD (counter=4) drops en at once.
        hold = 8'd5;
        req  = 4'b0001;
        tick(); expect_out("rh_on", 1'b1, 1'b1, 1'b1, 4'b0001);
        req = '0;
        tick(); expect_out("rh_hold", 1'b1, 1'b0, 1'b1, 4'b0000);
        reset = 1'b1;
        tick(); expect_out("rh_rst", 1'b0, 1'b0, 1'b0, 4'b0000);
        reset = 1'b0;
        tick(); expect_out("rh_rel0", 1'b0, 1'b0, 1'b0, 4'b0000);
        tick(); expect_out("rh_rel1", 1'b0, 1'b0, 1'b0, 4'b0000);

        // Changing hold during HOLD does not affect the running count.
        hold = 8'd2;
        req  = 4'b1000;
        tick(); expect_out("hc_on", 1'b1, 1'b1, 1'b1, 4'b1000);
        req = '0;
        tick(); expect_out("hc_hold0", 1'b1, 1'b0, 1'b1, 4'b0000);
        hold = 8'd200;
        tick(); expect_out("hc_hold1", 1'b1, 1'b0, 1'b1, 4'b0000);
        tick(); expect_out("hc_off", 1'b0, 1'b0, 1'b0, 4'b0000);

        // Request on the edge the counter reaches zero: stays on.
        hold = 8'd1;
        req  = 4'b0010;
        tick(); expect_out("sim_on", 1'b1, 1'b1, 1'b1, 4'b0010);
        req = '0;
        tick(); expect_out("sim_hold", 1'b1, 1'b0, 1'b1, 4'b0000);
        req = 4'b0010;
        tick(); expect_out("sim_win", 1'b1, 1'b0, 1'b1, 4'b0010);
        req = '0;
        tick(); expect_out("sim_hold2", 1'b1, 1'b0, 1'b1, 4'b0000);
        tick(); expect_out("sim_off", 1'b0, 1'b0, 1'b0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_clkreqor.md
Name: la_clkreqor

Overview:
- N-channel clock-request combiner.
- ORs per-channel clock requests into one registered clock-enable, then holds that enable for a programmable number of idle cycles after the last request drops.
- Drives the enable pin of a downstream integrated clock gate. Sits between clock-request sources and the gating cell.
- Generalises the plain 2-input clock OR: N channels, masking, force-on and idle hysteresis.

Parameters:
- N, 4, number of request channels (1..32).
- HOLDW, 8, width of hold-off counter and hold input.
- PROP, "DEFAULT", implementation property string; passed through, no functional effect.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- req  input  N  per-channel clock request; synchronous to clk, level-sensitive.
- mask  input  N  per-channel mask; 1 = ignore that channel's req.
- hold  input  HOLDW  idle cycles to keep enable high after last unmasked req drops; sampled on ON->HOLD transition.
- force_on  input  1  1 = enable forced high regardless of req.
- en  output  1  registered clock-enable for downstream gate.
- grant  output  N  registered per-channel indication: en high and that channel requesting, unmasked.
- wake  output  1  one-cycle pulse on the cycle en rises.
- busy  output  1  high when state is not OFF (ON or HOLD).

Behaviour:
- Reset:
  - reset is synchronous and active-high; while high at a clk edge: state=OFF, en=0, grant=0, wake=0, busy=0, counter=0.
  - Reset mid-HOLD or mid-ON drops en on the next edge; there is no hold-off on reset.
- any = |(req & ~mask) | force_on, combinational from current inputs.
- States: OFF, ON, HOLD. Encoding is free; busy = (state != OFF), registered.
- OFF:
  - any=1 -> ON; en<=1, wake<=1.
  - Otherwise stay in OFF with en=0.
- ON:
  - any=1 -> stay in ON.
  - any=0 and hold!=0 -> HOLD; counter<=hold-1.
  - any=0 and hold==0 -> OFF; en<=0.
- HOLD:
  - any=1 -> ON; counter is cleared; no wake pulse, because en never dropped.
  - any=0 and counter==0 -> OFF; en<=0.
  - Otherwise counter<=counter-1.
- Hold timing: with hold=H>0, en stays high exactly H cycles after the first edge where any=0 is sampled in ON.
- Latency: req to en is 1 cycle (en rises on the first edge sampling any=1).
- en: 1 in ON and HOLD, 0 in OFF.
- wake: high for exactly one cycle per OFF->ON transition.
- grant[i] <= next_en & req[i] & ~mask[i]. grant is 0 in HOLD unless that channel is requesting.
- mask change: takes effect on the same cycle it is sampled. Masking the only active channel behaves as a req drop.
- force_on=1:
  - Acts as an extra unmasked request.
  - grant reflects only real requests.
- hold is sampled only on ON->HOLD. Changing hold during HOLD has no effect on the running count.
- Counter saturation: none needed. The maximum hold is 2^HOLDW-1 cycles.
- Simultaneous events:
  - Request arriving on the exact edge the counter hits 0: any=1 wins, go to ON, en stays high.
  - Glitch-free requirement: en is a flop output only, never combinational.

Test Plan:
- Reset with req=4'b1111 -> en=0, busy=0, grant=0 for all reset cycles. First edge after reset release -> en=1, wake=1 for one cycle, grant=4'b1111.
- hold=3:
  - req[1] high 5 cycles, then low -> en=1 for the 5 request cycles plus exactly 3 more, then 0.
  - busy tracks en; grant[1] drops on the first idle cycle.
- hold=5, req[0] drops, then reasserts 2 cycles into HOLD -> en never drops, no second wake pulse, grant[0] returns 1 cycle after reassert.
- hold=0, single-cycle req[2] pulse -> en high exactly 1 cycle, wake pulse coincident.
- mask=4'b0100, req=4'b0100 -> en stays 0. Clearing mask[2] -> en=1 on next edge. force_on=1 with req=0 -> en=1, grant=0.
- Reset asserted during HOLD with counter=4 -> en=0, state OFF on that edge. Reset released with req=0 -> en stays 0.
